// File: rtl/button_pkg.sv
// Shared definitions for the 3x4 button matrix: column drive codes, matrix
// dimensions and key indexing helpers. The column scanner uses the same codes.
package button_pkg;

  localparam int KEY_NUM = 12;
  localparam int ROW_NUM = 4;
  localparam int COL_NUM = 3;

  // One-cold column drive codes
  localparam logic [2:0] COL0_CODE = 3'b110;
  localparam logic [2:0] COL1_CODE = 3'b101;
  localparam logic [2:0] COL2_CODE = 3'b011;

  typedef logic [KEY_NUM-1:0] key_map_t;
  typedef logic [3:0]         key_code_t;

  // Decoded column sample: valid is low for any code outside the three legal ones
  typedef struct packed {
    logic       valid;
    logic [1:0] col;
  } col_dec_t;

  // Key index of a matrix position: row*3 + col
  function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'(COL_NUM) + 4'(col);
  endfunction

  function automatic col_dec_t decode_col(input logic [2:0] code);
    col_dec_t d;
    d.valid = 1'b1;
    d.col   = 2'd0;
    case (code)
      COL0_CODE: d.col = 2'd0;
      COL1_CODE: d.col = 2'd1;
      COL2_CODE: d.col = 2'd2;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Lowest set index of a key map (0 when the map is empty)
  function automatic key_code_t lowest_key(input key_map_t keys);
    key_code_t idx;
    idx = '0;
    for (int k = KEY_NUM - 1; k >= 0; k--) begin
      if (keys[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_frame_debounce.sv
// Whole-frame debouncer: a new key map is accepted once DEBOUNCE_FRAMES
// consecutive complete frames are identical. keys_next is the value keys
// will take at the next edge, so the caller can detect new presses.
module button_frame_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     frame_valid,
  input  key_map_t frame,
  output key_map_t keys,
  output key_map_t keys_next
);

  localparam logic [3:0] STABLE_TARGET = 4'(DEBOUNCE_FRAMES - 1);

  key_map_t   prev_frame_q, prev_frame_d;
  key_map_t   keys_q, keys_d;
  logic [3:0] stable_cnt_q, stable_cnt_d;

  // Compare each complete frame against the previous one and promote a stable map
  always_comb begin
    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    keys_d       = keys_q;
    if (frame_valid) begin
      prev_frame_d = frame;
      if (frame == prev_frame_q) begin
        stable_cnt_d = (stable_cnt_q == 4'hF) ? stable_cnt_q : stable_cnt_q + 4'd1;
      end else begin
        stable_cnt_d = '0;
      end
      if (stable_cnt_d == STABLE_TARGET && frame != keys_q) begin
        keys_d = frame;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_frame_q <= '0;
      stable_cnt_q <= '0;
      keys_q       <= '0;
    end else begin
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      keys_q       <= keys_d;
    end
  end

  assign keys      = keys_q;
  assign keys_next = keys_d;

endmodule

// File: rtl/button_matrix_decoder.sv
// Row-side reader for the 3x4 button matrix. Synchronizes the row pins and
// the scanner column code, assembles 12-key frames, debounces them and
// reports presses. Optional auto-repeat is built when BUTTON_REPEAT_EN is
// defined.
// Output handshake: o_key_valid is a one-cycle pulse with no ready; the
// consumer must take o_key_code in the cycle o_key_valid is high.
module button_matrix_decoder
  import button_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES      = 4,
  parameter int REPEAT_DELAY_FRAMES  = 500,
  parameter int REPEAT_PERIOD_FRAMES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_sensor,
  input  logic [3:0]  i_rows,
  output logic [11:0] o_keys,
  output logic [3:0]  o_key_code,
  output logic        o_key_valid
);

  logic [3:0] rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
  logic [2:0] sens_s1_q, sens_s1_d, sens_s2_q, sens_s2_d;
  key_map_t   cur_frame_q, cur_frame_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_done;
  col_dec_t   col_dec;
  key_map_t   keys_cur, keys_next, new_keys;
  key_map_t   pend_keys_q, pend_keys_d;
  key_code_t  key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       rep_fire_q, rep_fire_d;

  // Row synchronizer and matching column-code delay keep samples aligned
  always_comb begin
    rows_s1_d = i_rows;
    rows_s2_d = rows_s1_q;
    sens_s1_d = i_sensor;
    sens_s2_d = sens_s1_q;
  end

  // Frame assembly: col0 opens a frame, col2 closes it, a bad code voids it
  always_comb begin
    cur_frame_d = cur_frame_q;
    frame_ok_d  = frame_ok_q;
    frame_done  = 1'b0;
    col_dec     = decode_col(sens_s2_q);
    if (!col_dec.valid) begin
      frame_ok_d = 1'b0;
    end else begin
      for (int r = 0; r < ROW_NUM; r++) begin
        cur_frame_d[key_index(2'(r), col_dec.col)] = ~rows_s2_q[r];
      end
      if (col_dec.col == 2'd0) begin
        frame_ok_d = 1'b1;
      end else if (col_dec.col == 2'd2) begin
        frame_done = frame_ok_q;
        frame_ok_d = 1'b0;
      end
    end
  end

  button_frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_done),
    .frame      (cur_frame_d),
    .keys       (keys_cur),
    .keys_next  (keys_next)
  );

  // Press encoder: newly set keys are held one cycle so the pulse trails o_keys
  always_comb begin
    new_keys    = keys_next & ~keys_cur;
    pend_keys_d = new_keys;
    key_valid_d = (|pend_keys_q) | rep_fire_q;
    key_code_d  = key_code_q;
    if (|pend_keys_q) key_code_d = lowest_key(pend_keys_q);
  end

`ifdef BUTTON_REPEAT_EN
  localparam logic [15:0] REP_DELAY  = 16'(REPEAT_DELAY_FRAMES);
  localparam logic [15:0] REP_PERIOD = 16'(REPEAT_PERIOD_FRAMES);

  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_active_q, rep_active_d;
  logic        rep_first_q, rep_first_d;

  // Auto-repeat: count frames while the last reported key stays held
  always_comb begin
    rep_cnt_d    = rep_cnt_q;
    rep_active_d = rep_active_q;
    rep_first_d  = rep_first_q;
    rep_fire_d   = 1'b0;
    if (|new_keys) begin
      rep_cnt_d    = '0;
      rep_active_d = 1'b1;
      rep_first_d  = 1'b0;
    end else if (frame_done) begin
      if (rep_active_q && keys_next[key_code_q]) begin
        if (rep_cnt_q + 16'd1 == (rep_first_q ? REP_PERIOD : REP_DELAY)) begin
          rep_fire_d  = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 16'd1;
        end
      end else begin
        rep_cnt_d    = '0;
        rep_active_d = 1'b0;
        rep_first_d  = 1'b0;
      end
    end
  end

  // Auto-repeat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q    <= '0;
      rep_active_q <= 1'b0;
      rep_first_q  <= 1'b0;
    end else begin
      rep_cnt_q    <= rep_cnt_d;
      rep_active_q <= rep_active_d;
      rep_first_q  <= rep_first_d;
    end
  end
`else
  // Repeat timing is not built in this configuration
  localparam int unused_repeat_cfg = REPEAT_DELAY_FRAMES + REPEAT_PERIOD_FRAMES;
  assign rep_fire_d = 1'b0;
`endif

  // Pipeline, frame and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_s1_q   <= 4'hF;
      rows_s2_q   <= 4'hF;
      sens_s1_q   <= 3'b111;
      sens_s2_q   <= 3'b111;
      cur_frame_q <= '0;
      frame_ok_q  <= 1'b0;
      pend_keys_q <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      rep_fire_q  <= 1'b0;
    end else begin
      rows_s1_q   <= rows_s1_d;
      rows_s2_q   <= rows_s2_d;
      sens_s1_q   <= sens_s1_d;
      sens_s2_q   <= sens_s2_d;
      cur_frame_q <= cur_frame_d;
      frame_ok_q  <= frame_ok_d;
      pend_keys_q <= pend_keys_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      rep_fire_q  <= rep_fire_d;
    end
  end

  assign o_keys      = keys_cur;
  assign o_key_code  = key_code_q;
  assign o_key_valid = key_valid_q;

endmodule

// File: tb/tb_button_matrix_decoder.sv
// Bench for button_matrix_decoder with DEBOUNCE_FRAMES = 4 and repeat
// timing 5/2 frames (repeat only active when BUTTON_REPEAT_EN is defined).
module tb_button_matrix_decoder;
  import button_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  i_sensor = 3'b111;
  logic [3:0]  i_rows = 4'hF;
  logic [11:0] o_keys;
  logic [3:0]  o_key_code;
  logic        o_key_valid;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       prev_valid = 1'b0;
  logic [3:0] exp_code;
  int         exp_cyc;

  button_matrix_decoder #(
    .DEBOUNCE_FRAMES     (4),
    .REPEAT_DELAY_FRAMES (5),
    .REPEAT_PERIOD_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sensor   (i_sensor),
    .i_rows     (i_rows),
    .o_keys     (o_keys),
    .o_key_code (o_key_code),
    .o_key_valid(o_key_valid)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One scanner sample; col < 0 means an illegal code with random rows
  task automatic drive_sample(input logic [2:0] code, input int col, input logic [11:0] map);
    @(posedge clk);
    #1;
    i_sensor = code;
    for (int r = 0; r < 4; r++) begin
      if (col < 0) i_rows[r] = 1'($urandom_range(0, 1));
      else         i_rows[r] = ~map[r * 3 + col];
    end
  endtask

  // One full scanner frame. A pulse triggered by this frame is visible
  // 6 cycles after its col0 sample is driven (2 sync + 3 samples + 1).
  task automatic drive_frame(input logic [11:0] map, input bit bad_col1,
                             input bit expect_pulse, input logic [3:0] code);
    drive_sample(COL0_CODE, 0, map);
    if (expect_pulse) begin
      exp_q.push_back(code);
      exp_cyc_q.push_back(cyc + 6);
    end
    if (bad_col1) drive_sample(3'b111, -1, map);
    else          drive_sample(COL1_CODE, 1, map);
    drive_sample(COL2_CODE, 2, map);
  endtask

  task automatic frames(input logic [11:0] map, input int n);
    for (int f = 0; f < n; f++) drive_frame(map, 1'b0, 1'b0, 4'd0);
  endtask

  // Let the last frame complete before reading o_keys
  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && o_key_valid) begin
      check("no_back_to_back", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: code %0d at cycle %0d, no pulse expected", o_key_code, cyc);
      end else begin
        exp_code = exp_q.pop_front();
        exp_cyc  = exp_cyc_q.pop_front();
        check("pulse_code", 32'(o_key_code), 32'(exp_code));
        check("pulse_cycle", 32'(cyc), 32'(exp_cyc));
      end
    end
    prev_valid = o_key_valid;
  end

  initial begin
    // Reset with random pins
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      i_rows   = 4'($urandom_range(0, 15));
      i_sensor = 3'($urandom_range(0, 7));
    end
    check("reset_keys", 32'(o_keys), 32'h000);
    check("reset_valid", 32'(o_key_valid), 32'd0);
    check("reset_code", 32'(o_key_code), 32'd0);
    rst = 1'b0;

    // Partial frame right after reset, everything pressed
    drive_sample(COL1_CODE, 1, 12'hFFF);
    drive_sample(COL2_CODE, 2, 12'hFFF);
    frames(12'h000, 5);
    settle();
    check("after_partial_keys", 32'(o_keys), 32'h000);

    // Single press of key 7: fourth identical frame accepts it
    for (int f = 0; f < 6; f++) drive_frame(12'h080, 1'b0, f == 3, 4'd7);
    settle();
    check("press7_keys", 32'(o_keys), 32'h080);
    frames(12'h000, 6);
    settle();
    check("release7_keys", 32'(o_keys), 32'h000);

    // Bounce: key 3 toggles every frame
    for (int f = 0; f < 10; f++) drive_frame((f % 2 == 0) ? 12'h008 : 12'h000, 1'b0, 1'b0, 4'd0);
    frames(12'h000, 6);
    settle();
    check("bounce_keys", 32'(o_keys), 32'h000);

    // Keys 2 and 9 together: one pulse with the lower code
    for (int f = 0; f < 6; f++) drive_frame(12'h204, 1'b0, f == 3, 4'd2);
    settle();
    check("dual_keys", 32'(o_keys), 32'h204);
    frames(12'h200, 6);
    settle();
    check("release2_keys", 32'(o_keys), 32'h200);
    frames(12'h000, 6);
    settle();
    check("release9_keys", 32'(o_keys), 32'h000);

    // Key 5 with illegal column codes: bad frames never count toward debounce
    drive_frame(12'h020, 1'b1, 1'b0, 4'd0);
    drive_frame(12'h020, 1'b0, 1'b0, 4'd0);
    drive_frame(12'h020, 1'b0, 1'b0, 4'd0);
    drive_frame(12'h020, 1'b1, 1'b0, 4'd0);
    drive_frame(12'h020, 1'b0, 1'b0, 4'd0);
    settle();
    check("bad_frame_keys", 32'(o_keys), 32'h000);
    drive_frame(12'h020, 1'b0, 1'b1, 4'd5);
    frames(12'h020, 2);
    settle();
    check("press5_keys", 32'(o_keys), 32'h020);
    frames(12'h000, 6);
    settle();
    check("release5_keys", 32'(o_keys), 32'h000);

    // Hold key 11 for 14 frames, then release for 8
`ifdef BUTTON_REPEAT_EN
    // Press on frame 4, repeats on frames 9, 11, 13; o_keys still holds the
    // key through release frames 1-3, so repeats also land on release 1 and 3
    for (int f = 1; f <= 14; f++)
      drive_frame(12'h800, 1'b0, (f == 4 || f == 9 || f == 11 || f == 13), 4'd11);
    for (int f = 1; f <= 8; f++)
      drive_frame(12'h000, 1'b0, (f == 1 || f == 3), 4'd11);
`else
    for (int f = 1; f <= 14; f++) drive_frame(12'h800, 1'b0, f == 4, 4'd11);
    frames(12'h000, 8);
`endif
    settle();
    check("release11_keys", 32'(o_keys), 32'h000);

    repeat (10) @(posedge clk);
    #1;
    check("pending_pulses", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
